// File: rtl/program_feeder.sv
// Host-side feeder for the 8-bit common-bus CPU: loads a small program RAM, serves
// instructions at the CPU's PC and emits a trace record for each PC change.
module program_feeder #(
    parameter int DEPTH      = 64,
    parameter int MAX_CYCLES = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load_valid,
    input  logic [13:0] load_data,
    input  logic        load_last,
    output logic        load_ready,
    input  logic        run_start,
    output logic [13:0] cpu_instruction,
    output logic        cpu_out_sel,
    input  logic [7:0]  cpu_value,
    output logic        trace_valid,
    output logic [7:0]  trace_pc,
    output logic [7:0]  trace_reg,
    output logic        busy,
    output logic        done,
    output logic        timeout
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);
    localparam int CW = $clog2(MAX_CYCLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN_PC, S_RUN_REG, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [LW-1:0] ptr_q, ptr_d, len_q, len_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]  last_pc_q, last_pc_d;
    logic [7:0]  trace_pc_q, trace_pc_d;
    logic [7:0]  trace_reg_q, trace_reg_d;
    logic [13:0] instr_q, instr_d;
    logic        trace_valid_q, trace_valid_d;
    logic        done_q, done_d;
    logic        timeout_q, timeout_d;
    logic        drop_q, drop_d;

    logic          we;
    logic [AW-1:0] waddr;
    logic [13:0]   mem [DEPTH];
    logic [5:0]    idx;
    logic          in_prog;
    logic          budget_out;

    assign idx        = cpu_value[7:2];
    assign in_prog    = (32'(idx) < 32'(len_q));
    assign budget_out = (cnt_q == CW'(MAX_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= load_data;
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        len_d         = len_q;
        cnt_d         = cnt_q;
        last_pc_d     = last_pc_q;
        trace_pc_d    = trace_pc_q;
        trace_reg_d   = trace_reg_q;
        instr_d       = 14'd0;
        trace_valid_d = 1'b0;
        done_d        = done_q;
        timeout_d     = timeout_q;
        drop_d        = drop_q;
        we            = 1'b0;
        waddr         = ptr_q[AW-1:0];

        case (state_q)
            S_IDLE, S_DONE: begin
                if (load_valid) begin
                    // After an overflowing load, the rest of that stream is swallowed up to its last word.
                    if (drop_q) begin
                        if (load_last) begin
                            drop_d = 1'b0;
                        end
                    end else begin
                        we        = 1'b1;
                        waddr     = '0;
                        ptr_d     = LW'(1);
                        len_d     = load_last ? LW'(1) : '0;
                        done_d    = 1'b0;
                        timeout_d = 1'b0;
                        state_d   = load_last ? S_IDLE : S_LOAD;
                    end
                end else if (run_start) begin
                    if (len_q == '0) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        cnt_d     = '0;
                        last_pc_d = 8'd0;
                        state_d   = S_RUN_PC;
                    end
                end
            end
            S_LOAD: begin
                if (load_valid) begin
                    we    = 1'b1;
                    ptr_d = ptr_q + LW'(1);
                    if (load_last || (ptr_q == LW'(DEPTH - 1))) begin
                        len_d   = ptr_q + LW'(1);
                        drop_d  = !load_last;
                        state_d = S_IDLE;
                    end
                end
            end
            S_RUN_PC: begin
                if (budget_out) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (!in_prog) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        instr_d = mem[idx[AW-1:0]];
                        if (cpu_value != last_pc_q) begin
                            trace_pc_d = last_pc_q;
                            last_pc_d  = cpu_value;
                            state_d    = S_RUN_REG;
                        end
                    end
                end
            end
            S_RUN_REG: begin
                if (budget_out) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    cnt_d         = cnt_q + CW'(1);
                    instr_d       = instr_q;
                    trace_reg_d   = cpu_value;
                    trace_valid_d = 1'b1;
                    state_d       = S_RUN_PC;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            ptr_q         <= '0;
            len_q         <= '0;
            cnt_q         <= '0;
            last_pc_q     <= 8'd0;
            trace_pc_q    <= 8'd0;
            trace_reg_q   <= 8'd0;
            instr_q       <= 14'd0;
            trace_valid_q <= 1'b0;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
            drop_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            len_q         <= len_d;
            cnt_q         <= cnt_d;
            last_pc_q     <= last_pc_d;
            trace_pc_q    <= trace_pc_d;
            trace_reg_q   <= trace_reg_d;
            instr_q       <= instr_d;
            trace_valid_q <= trace_valid_d;
            done_q        <= done_d;
            timeout_q     <= timeout_d;
            drop_q        <= drop_d;
        end
    end

    assign load_ready      = !reset && (state_q inside {S_IDLE, S_LOAD, S_DONE});
    assign busy            = (state_q inside {S_LOAD, S_RUN_PC, S_RUN_REG});
    assign cpu_out_sel     = (state_q == S_RUN_REG);
    assign cpu_instruction = instr_q;
    assign trace_valid     = trace_valid_q;
    assign trace_pc        = trace_pc_q;
    assign trace_reg       = trace_reg_q;
    assign done            = done_q;
    assign timeout         = timeout_q;

endmodule

// File: tb/tb_program_feeder.sv
// Bench for program_feeder: directed scenarios plus randomized load/run traffic,
// all checked each cycle against a behavioural model of the feeder.
module tb_program_feeder;

    localparam int DEPTH = 64;
    localparam int MAXC  = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        load_valid;
    logic [13:0] load_data;
    logic        load_last;
    logic        load_ready;
    logic        run_start;
    logic [13:0] cpu_instruction;
    logic        cpu_out_sel;
    logic [7:0]  cpu_value;
    logic        trace_valid;
    logic [7:0]  trace_pc;
    logic [7:0]  trace_reg;
    logic        busy;
    logic        done;
    logic        timeout;

    always #5 clock = ~clock;

    program_feeder #(.DEPTH(DEPTH), .MAX_CYCLES(MAXC)) dut (
        .clock(clock), .reset(reset),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(load_ready), .run_start(run_start),
        .cpu_instruction(cpu_instruction), .cpu_out_sel(cpu_out_sel),
        .cpu_value(cpu_value), .trace_valid(trace_valid), .trace_pc(trace_pc),
        .trace_reg(trace_reg), .busy(busy), .done(done), .timeout(timeout)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Behavioural model: what the feeder is doing and what it should be showing.
    typedef enum {M_IDLE, M_LOAD, M_PC, M_REG, M_DONE} mode_t;
    mode_t       m_mode = M_IDLE;
    logic [13:0] m_prog [DEPTH];
    int          m_len = 0, m_ptr = 0, m_cyc = 0;
    logic [7:0]  m_last = 0, m_tpc = 0, m_treg = 0;
    logic [13:0] m_instr = 0;
    bit          m_tv = 0, m_done = 0, m_to = 0, m_drop = 0;

    task automatic model_step(input bit r, input bit lv, input bit ll, input bit rs,
                              input logic [13:0] ld, input logic [7:0] cv);
        int pidx;
        m_tv = 0;
        if (r) begin
            m_mode = M_IDLE; m_len = 0; m_ptr = 0; m_cyc = 0; m_last = 0;
            m_tpc = 0; m_treg = 0; m_instr = 0; m_done = 0; m_to = 0; m_drop = 0;
            return;
        end
        pidx = int'(cv) / 4;
        case (m_mode)
            M_IDLE, M_DONE: begin
                m_instr = 0;
                if (lv) begin
                    if (m_drop) begin
                        if (ll) m_drop = 0;
                    end else begin
                        m_prog[0] = ld; m_ptr = 1; m_done = 0; m_to = 0;
                        m_len  = ll ? 1 : 0;
                        m_mode = ll ? M_IDLE : M_LOAD;
                    end
                end else if (rs) begin
                    if (m_len == 0) begin
                        m_done = 1; m_mode = M_DONE;
                    end else begin
                        m_cyc = 0; m_last = 0; m_mode = M_PC;
                    end
                end
            end
            M_LOAD: begin
                m_instr = 0;
                if (lv) begin
                    m_prog[m_ptr] = ld;
                    m_ptr++;
                    if (ll || m_ptr == DEPTH) begin
                        m_len = m_ptr; m_drop = !ll; m_mode = M_IDLE;
                    end
                end
            end
            M_PC: begin
                m_cyc++;
                if (m_cyc == MAXC) begin
                    m_to = 1; m_instr = 0; m_mode = M_DONE;
                end else if (pidx >= m_len) begin
                    m_done = 1; m_instr = 0; m_mode = M_DONE;
                end else begin
                    m_instr = m_prog[pidx];
                    if (cv != m_last) begin
                        m_tpc = m_last; m_last = cv; m_mode = M_REG;
                    end
                end
            end
            M_REG: begin
                m_cyc++;
                if (m_cyc == MAXC) begin
                    m_to = 1; m_instr = 0; m_mode = M_DONE;
                end else begin
                    m_treg = cv; m_tv = 1; m_mode = M_PC;
                end
            end
            default: m_mode = M_IDLE;
        endcase
    endtask

    task automatic compare_all();
        bit exp_ready;
        exp_ready = !reset && (m_mode == M_IDLE || m_mode == M_LOAD || m_mode == M_DONE);
        check_val("load_ready", 32'(load_ready), 32'(exp_ready));
        check_val("busy", 32'(busy), 32'(m_mode == M_LOAD || m_mode == M_PC || m_mode == M_REG));
        check_val("cpu_out_sel", 32'(cpu_out_sel), 32'(m_mode == M_REG));
        check_val("cpu_instruction", 32'(cpu_instruction), 32'(m_instr));
        check_val("trace_valid", 32'(trace_valid), 32'(m_tv));
        check_val("trace_pc", 32'(trace_pc), 32'(m_tpc));
        check_val("trace_reg", 32'(trace_reg), 32'(m_treg));
        check_val("done", 32'(done), 32'(m_done));
        check_val("timeout", 32'(timeout), 32'(m_to));
    endtask

    task automatic tick();
        bit r, lv, ll, rs;
        logic [13:0] ld;
        logic [7:0]  cv;
        r = reset; lv = load_valid; ll = load_last; rs = run_start; ld = load_data; cv = cpu_value;
        @(posedge clock);
        model_step(r, lv, ll, rs, ld, cv);
        #1;
        compare_all();
    endtask

    task automatic load_word(input logic [13:0] d, input bit last);
        load_valid = 1; load_data = d; load_last = last;
        tick();
        load_valid = 0; load_last = 0;
    endtask

    task automatic start_run();
        run_start = 1;
        tick();
        run_start = 0;
    endtask

    // Present the PC, or the output register while the feeder has the select line up.
    task automatic run_cycle(input logic [7:0] pc, input logic [7:0] regv);
        cpu_value = (m_mode == M_REG) ? regv : pc;
        tick();
    endtask

    task automatic finish_run(input logic [7:0] pc);
        for (int i = 0; i < 3 * MAXC && m_mode != M_DONE; i++) run_cycle(pc, 8'h11);
        check_val("run_ends", 32'(m_mode == M_DONE), 32'(1));
    endtask

    logic [13:0] words [70];

    initial begin
        reset = 1; load_valid = 0; load_data = 0; load_last = 0; run_start = 0; cpu_value = 0;
        tick();
        tick();
        check_val("rst_instr", 32'(cpu_instruction), 32'(0));
        check_val("rst_ready", 32'(load_ready), 32'(0));
        reset = 0;
        tick();

        // Three-word program, then a traced walk 0x00 -> 0x04 -> 0x08 -> 0x0C.
        load_word(14'h0041, 0);
        load_word(14'h0822, 0);
        load_word(14'h1003, 1);
        check_val("load_busy_low", 32'(busy), 32'(0));
        start_run();
        for (int i = 0; i < 5; i++) run_cycle(8'h00, 8'h00);
        check_val("instr_w0", 32'(cpu_instruction), 32'(14'h0041));
        run_cycle(8'h04, 8'h2A);
        check_val("sel_high", 32'(cpu_out_sel), 32'(1));
        check_val("trace_pc_0", 32'(trace_pc), 32'(8'h00));
        check_val("instr_w1", 32'(cpu_instruction), 32'(14'h0822));
        run_cycle(8'h04, 8'h2A);
        check_val("sel_one_cycle", 32'(cpu_out_sel), 32'(0));
        check_val("tv_pulse", 32'(trace_valid), 32'(1));
        check_val("treg_2a", 32'(trace_reg), 32'(8'h2A));
        run_cycle(8'h08, 8'h55);
        run_cycle(8'h08, 8'h55);
        run_cycle(8'h0C, 8'h00);
        check_val("done_end", 32'(done), 32'(1));
        check_val("done_instr0", 32'(cpu_instruction), 32'(0));
        check_val("done_busy0", 32'(busy), 32'(0));

        // Cycle budget exhaustion with the PC parked.
        load_word(14'h0041, 0);
        load_word(14'h0822, 0);
        load_word(14'h1003, 1);
        start_run();
        for (int i = 1; i <= MAXC; i++) begin
            run_cycle(8'h00, 8'h00);
            if (i == MAXC - 1) check_val("pre_timeout", 32'(timeout), 32'(0));
        end
        check_val("timeout_set", 32'(timeout), 32'(1));
        check_val("timeout_not_done", 32'(done), 32'(0));

        // 70-word stream into a 64-entry RAM.
        for (int i = 0; i < 70; i++) words[i] = 14'($urandom) | 14'h1;
        for (int i = 0; i < 70; i++) load_word(words[i], i == 69);
        start_run();
        run_cycle(8'h00, 8'h00);
        check_val("ovf_w0", 32'(cpu_instruction), 32'(words[0]));
        run_cycle(8'hFC, 8'h77);
        check_val("ovf_w63", 32'(cpu_instruction), 32'(words[63]));
        finish_run(8'hFC);

        // Reset in the middle of a load discards the program.
        load_word(14'h0123, 0);
        load_word(14'h0456, 0);
        reset = 1;
        tick();
        reset = 0;
        start_run();
        check_val("rst_load_done", 32'(done), 32'(1));
        check_val("rst_load_no_tv", 32'(trace_valid), 32'(0));

        // Randomized programs and PC walks.
        for (int it = 0; it < 40; it++) begin
            int len, pc, rst_at;
            if (it % 3 != 2 || m_len == 0) begin
                len = 1 + ($urandom % 10);
                for (int w = 0; w < len; w++) begin
                    while ($urandom % 3 == 0) begin
                        run_start = (w > 0) && ($urandom % 2 == 0);
                        tick();
                        run_start = 0;
                    end
                    load_word(14'($urandom), w == len - 1);
                end
            end
            start_run();
            pc = 0;
            rst_at = (it % 7 == 3) ? int'($urandom % 12) : -1;
            for (int c = 0; c < 40 && m_mode != M_DONE; c++) begin
                if (c == rst_at) begin
                    reset = 1;
                    tick();
                    reset = 0;
                    break;
                end
                if (m_mode == M_PC) begin
                    case ($urandom % 4)
                        0:       pc = pc;
                        1, 2:    pc = (pc + 4) % 256;
                        default: pc = int'($urandom % (m_len + 2)) * 4;
                    endcase
                end
                run_cycle(8'(pc), 8'($urandom));
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1);
    end

endmodule
